// File: rtl/au_addsub_mw.sv
// Word-serial multi-word adder-subtractor: one WIDTH-bit chunk per cycle, LS chunk first.
// Optional signed-overflow output enabled by defining AU_ADDSUB_MW_OVF_EN.
module au_addsub_mw #(
    parameter int WIDTH = 8,
    parameter int NWORD = 4,
    parameter int ARCH  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH*NWORD-1:0]   a,
    input  logic [WIDTH*NWORD-1:0]   b,
    input  logic                     ci,
    input  logic                     add_sub,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH*NWORD-1:0]   s,
    output logic                     co
`ifdef AU_ADDSUB_MW_OVF_EN
    ,
    output logic                     ovf
`endif
);

    localparam int N  = WIDTH * NWORD;
    localparam int CW = (NWORD > 1) ? $clog2(NWORD) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_r;
    logic [N-1:0]     a_r;
    logic [N-1:0]     b_r;
    logic             sub_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic [N-1:0]     s_r;
    logic             co_r;
    logic             in_ready_r;
    logic             out_valid_r;

    logic [WIDTH-1:0] a_chunk_s;
    logic [WIDTH-1:0] b_chunk_s;
    logic [WIDTH-1:0] g_s;
    logic [WIDTH-1:0] p_s;
    logic             cin_s;
    logic [WIDTH:0]   c_s;
    logic [WIDTH-1:0] sum_s;
    logic             slice_co_s;
    logic             last_s;

    // Chunk operand selection; subtraction is a + ~b with the borrow folded into the carry-in
    always_comb begin
        a_chunk_s = a_r[cnt_r*WIDTH +: WIDTH];
        b_chunk_s = b_r[cnt_r*WIDTH +: WIDTH] ^ {WIDTH{sub_r}};
        g_s       = a_chunk_s & b_chunk_s;
        p_s       = a_chunk_s ^ b_chunk_s;
        cin_s     = carry_r ^ sub_r;
    end

    generate
        if (ARCH == 0) begin : g_serial
            // Serial prefix over generate/propagate pairs
            always_comb begin
                logic [WIDTH:0] c_v;
                c_v    = '0;
                c_v[0] = cin_s;
                for (int i = 0; i < WIDTH; i++) begin
                    c_v[i+1] = g_s[i] | (p_s[i] & c_v[i]);
                end
                c_s = c_v;
            end
        end else begin : g_parallel
            // Log-depth (Kogge-Stone) prefix with carry-in merged into bit 0
            always_comb begin
                logic [WIDTH-1:0] gg_v;
                logic [WIDTH-1:0] pp_v;
                gg_v    = g_s;
                pp_v    = p_s;
                gg_v[0] = g_s[0] | (p_s[0] & cin_s);
                for (int d = 1; d < WIDTH; d = d * 2) begin
                    for (int i = WIDTH - 1; i >= d; i--) begin
                        gg_v[i] = gg_v[i] | (pp_v[i] & gg_v[i-d]);
                        pp_v[i] = pp_v[i] & pp_v[i-d];
                    end
                end
                c_s = {gg_v, cin_s};
            end
        end
    endgenerate

    // Slice result; in subtract mode the outgoing carry is inverted into a borrow
    always_comb begin
        sum_s      = p_s ^ c_s[WIDTH-1:0];
        slice_co_s = c_s[WIDTH] ^ sub_r;
        last_s     = (cnt_r == CW'(NWORD - 1));
    end

`ifdef AU_ADDSUB_MW_OVF_EN
    logic ovf_r;

    // Signed overflow, evaluated when the top chunk is produced
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (state_r == RUN && last_s) begin
            ovf_r <= (a_r[N-1] == (b_r[N-1] ^ sub_r)) && (sum_s[WIDTH-1] != a_r[N-1]);
        end
    end

    assign ovf = ovf_r;
`endif

    // Control FSM, operand capture and per-chunk result write-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            sub_r       <= 1'b0;
            carry_r     <= 1'b0;
            cnt_r       <= '0;
            s_r         <= '0;
            co_r        <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r        <= a;
                        b_r        <= b;
                        sub_r      <= add_sub;
                        carry_r    <= ci;
                        cnt_r      <= '0;
                        in_ready_r <= 1'b0;
                        state_r    <= RUN;
                    end
                end
                RUN: begin
                    s_r[cnt_r*WIDTH +: WIDTH] <= sum_s;
                    carry_r                   <= slice_co_s;
                    if (last_s) begin
                        co_r        <= slice_co_s;
                        cnt_r       <= '0;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign s         = s_r;
    assign co        = co_r;

endmodule

// File: tb/tb_au_addsub_mw.sv
// Directed bench for au_addsub_mw (WIDTH=4, NWORD=4) with a result scoreboard.
module tb_au_addsub_mw;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        ci;
    logic        add_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        co;
`ifdef AU_ADDSUB_MW_OVF_EN
    logic        ovf;
`endif

    typedef struct packed {
        logic [15:0] s;
        logic        co;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;
    int   n_checks;

    au_addsub_mw #(.WIDTH(4), .NWORD(4), .ARCH(0)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .add_sub   (add_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co)
`ifdef AU_ADDSUB_MW_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: full 16-bit arithmetic, independent of chunking
    function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb_,
                                   input logic tci, input logic tsub);
        logic [16:0] t;
        logic [15:0] bi;
        exp_t        e;
        bi    = tsub ? ~tb_ : tb_;
        t     = {1'b0, ta} + {1'b0, bi} + {16'd0, (tsub ? ~tci : tci)};
        e.s   = t[15:0];
        e.co  = t[16] ^ tsub;
        e.ovf = (ta[15] == bi[15]) && (t[15] != ta[15]);
        return e;
    endfunction

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tci,
                          input logic tsub, input int hold, input logic early_ready);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        a = ta; b = tb_; ci = tci; add_sub = tsub; in_valid = 1'b1;
        @(posedge clk); #1;
        sb.push_back(model(ta, tb_, tci, tsub));
        vectors++;
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); add_sub = 1'($urandom);
        out_ready = early_ready;
        check("in_ready_busy", {31'd0, in_ready}, 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'd4);
        if (sb.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        check("s", {16'd0, s}, {16'd0, e.s});
        check("co", {31'd0, co}, {31'd0, e.co});
`ifdef AU_ADDSUB_MW_OVF_EN
        check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
`endif
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom); add_sub = 1'($urandom);
            @(posedge clk); #1;
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_s", {16'd0, s}, {16'd0, e.s});
            check("bp_co", {31'd0, co}, {31'd0, e.co});
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("drain_out_valid", {31'd0, out_valid}, 32'd0);
        check("drain_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        vectors = 0; miscompares = 0; n_checks = 0;
        rst_n = 1'b0; in_valid = 1'b0; a = 16'd0; b = 16'd0;
        ci = 1'b0; add_sub = 1'b0; out_ready = 1'b0;
        #12;
        check("rst_s", {16'd0, s}, 32'd0);
        check("rst_co", {31'd0, co}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 1'b1);
        run_op(16'h1000, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
        run_op(16'h0001, 16'h0002, 1'b0, 1'b1, 0, 1'b0);
        run_op(16'h0005, 16'h0002, 1'b1, 1'b1, 0, 1'b0);
        run_op(16'hA5C3, 16'h5A3C, 1'b1, 1'b0, 5, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 1'b1, 0, 1'b0);

        // Abort while the third chunk is pending
        a = 16'h4321; b = 16'h1111; ci = 1'b0; add_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        sb.push_back(model(16'h4321, 16'h1111, 1'b0, 1'b0));
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_s", {16'd0, s}, 32'd0);
        check("abort_co", {31'd0, co}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        void'(sb.pop_back());
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_no_valid", {31'd0, out_valid}, 32'd0);
        end
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            check("post_abort_idle", {31'd0, out_valid}, 32'd0);
        end
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0);

`ifdef AU_ADDSUB_MW_OVF_EN
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 0, 1'b0);
`endif

        for (int i = 0; i < 6; i++) begin
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 0, 1'b0);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
